// File: rtl/jal_issue_buffer.sv
// Unordered reservation buffer for JAL/JALR micro-ops between dispatch and the JAL issue stage.
// Latency: a push accepted at edge N is visible in malloc/issue_info after edge N; pops free a slot at the sampling edge.
// Backpressure: full is registered-state only; a push while full, or any push during flush, is dropped.

`ifndef JAL_ISSUE_INFO_DW
`define JAL_ISSUE_INFO_DW 77
`endif
`ifndef JAL_ISSUE_INFO_DP
`define JAL_ISSUE_INFO_DP 4
`endif

module jal_issue_buffer #(
    parameter int DW = `JAL_ISSUE_INFO_DW,
    parameter int DP = `JAL_ISSUE_INFO_DP
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  jal_dispat_push,
    input  logic [DW-1:0]         jal_dispat_info,
    output logic                  jal_buffer_full,
    output logic                  jal_buffer_empty,
    output logic [DP-1:0]         jal_buffer_malloc,
    output logic [DW*DP-1:0]      jal_issue_info,
    input  logic                  jal_buffer_pop,
    input  logic [$clog2(DP)-1:0] jal_buffer_pop_index,
    input  logic                  flush
);

    localparam int IW = $clog2(DP);

    logic [DP-1:0]         malloc_q;
    logic [DP-1:0][DW-1:0] info_q;
    logic [IW-1:0]         push_idx;
    logic                  push_acc;
    logic                  pop_en;

    // Status comes from registered state only, so no input-to-output combinational path exists.
    assign jal_buffer_full   = &malloc_q;
    assign jal_buffer_empty  = ~|malloc_q;
    assign jal_buffer_malloc = malloc_q;
    assign jal_issue_info    = info_q;

    assign push_acc = jal_dispat_push & ~jal_buffer_full & ~flush;
    assign pop_en   = jal_buffer_pop & ~flush;

    // Priority encoder: lowest free slot, computed from pre-pop state so a slot freed this cycle is not reused.
    always_comb begin
        logic found;
        push_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < DP; i++) begin
            if (!malloc_q[i] && !found) begin
                push_idx = IW'(i);
                found    = 1'b1;
            end
        end
    end

    // Allocation bits: flush wins; otherwise pop clears and push sets (push only targets a slot free before this edge).
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            malloc_q <= '0;
        end else if (flush) begin
            malloc_q <= '0;
        end else begin
            if (pop_en) begin
                malloc_q[jal_buffer_pop_index] <= 1'b0;
            end
            if (push_acc) begin
                malloc_q[push_idx] <= 1'b1;
            end
        end
    end

    // Payload storage: written only on an accepted push; pop and flush leave stale data masked by malloc.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            info_q <= '0;
        end else if (push_acc) begin
            info_q[push_idx] <= jal_dispat_info;
        end
    end

endmodule

// File: tb/tb_jal_issue_buffer.sv
module tb_jal_issue_buffer;

    localparam int DW = 77;
    localparam int DP = 4;

    logic            CLK = 1'b0;
    logic            RSTn;
    logic            jal_dispat_push;
    logic [DW-1:0]   jal_dispat_info;
    logic            jal_buffer_full;
    logic            jal_buffer_empty;
    logic [DP-1:0]   jal_buffer_malloc;
    logic [DW*DP-1:0] jal_issue_info;
    logic            jal_buffer_pop;
    logic [1:0]      jal_buffer_pop_index;
    logic            flush;

    int checks   = 0;
    int failures = 0;
    int dropped_seen = 0;

    always #5 CLK = ~CLK;

    jal_issue_buffer #(.DW(DW), .DP(DP)) dut (
        .CLK                  (CLK),
        .RSTn                 (RSTn),
        .jal_dispat_push      (jal_dispat_push),
        .jal_dispat_info      (jal_dispat_info),
        .jal_buffer_full      (jal_buffer_full),
        .jal_buffer_empty     (jal_buffer_empty),
        .jal_buffer_malloc    (jal_buffer_malloc),
        .jal_issue_info       (jal_issue_info),
        .jal_buffer_pop       (jal_buffer_pop),
        .jal_buffer_pop_index (jal_buffer_pop_index),
        .flush                (flush)
    );

    typedef struct {
        logic        push;
        logic [63:0] pc;
        logic        pop;
        logic [1:0]  pidx;
        logic        fl;
        logic [3:0]  exp_malloc;
        logic        exp_full;
        logic        exp_empty;
        int          slot;      // slot whose payload is checked, -1 for none
        logic [63:0] slot_pc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    // {jal, jalr, pc, rd0, rs1, is_rvc}
    function automatic logic [DW-1:0] mk(input logic [63:0] pc);
        return {1'b1, 1'b0, pc, 5'd1, 5'd2, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic push, input logic [63:0] pc, input logic pop,
                               input logic [1:0] pidx, input logic fl, input logic [3:0] m,
                               input logic f, input logic e, input int s, input logic [63:0] spc);
        vec_t r;
        r.push = push; r.pc = pc; r.pop = pop; r.pidx = pidx; r.fl = fl;
        r.exp_malloc = m; r.exp_full = f; r.exp_empty = e; r.slot = s; r.slot_pc = spc;
        return r;
    endfunction

    task automatic idle_inputs();
        jal_dispat_push      = 1'b0;
        jal_dispat_info      = '0;
        jal_buffer_pop       = 1'b0;
        jal_buffer_pop_index = 2'd0;
        flush                = 1'b0;
    endtask

    initial begin
        vec_t cur, exp;
        logic [DW-1:0] slot_val;

        //        push pc         pop idx fl  malloc   full empty slot pc
        vecs.push_back(v(1, 64'h1000, 0, 0, 0, 4'b0001, 0, 0, 0, 64'h1000));
        vecs.push_back(v(1, 64'h1004, 0, 0, 0, 4'b0011, 0, 0, 1, 64'h1004));
        vecs.push_back(v(1, 64'h1008, 0, 0, 0, 4'b0111, 0, 0, 2, 64'h1008));
        vecs.push_back(v(1, 64'h100C, 0, 0, 0, 4'b1111, 1, 0, 3, 64'h100C));
        vecs.push_back(v(1, 64'h2000, 0, 0, 0, 4'b1111, 1, 0, 0, 64'h1000)); // dropped push
        vecs.push_back(v(0, 64'h0,    1, 1, 0, 4'b1101, 0, 0, 1, 64'h1004));
        vecs.push_back(v(1, 64'h3000, 0, 0, 0, 4'b1111, 1, 0, 1, 64'h3000));
        vecs.push_back(v(0, 64'h0,    0, 0, 1, 4'b0000, 0, 1, 1, 64'h3000));
        vecs.push_back(v(1, 64'h5000, 0, 0, 0, 4'b0001, 0, 0, 0, 64'h5000));
        vecs.push_back(v(1, 64'h5004, 0, 0, 0, 4'b0011, 0, 0, 1, 64'h5004));
        vecs.push_back(v(1, 64'h4000, 1, 0, 0, 4'b0110, 0, 0, 2, 64'h4000)); // push+pop
        vecs.push_back(v(0, 64'h0,    0, 0, 0, 4'b0110, 0, 0, 0, 64'h5000)); // slot 0 not reused
        vecs.push_back(v(1, 64'h6000, 0, 0, 0, 4'b0111, 0, 0, 0, 64'h6000));
        vecs.push_back(v(1, 64'h6004, 0, 0, 0, 4'b1111, 1, 0, 3, 64'h6004));
        vecs.push_back(v(1, 64'h7000, 1, 3, 0, 4'b0111, 0, 0, 3, 64'h6004)); // full: pop, push dropped
        vecs.push_back(v(1, 64'h8000, 0, 0, 0, 4'b1111, 1, 0, 3, 64'h8000));
        vecs.push_back(v(0, 64'h0,    1, 2, 0, 4'b1011, 0, 0, 2, 64'h4000));
        vecs.push_back(v(1, 64'h9000, 1, 0, 1, 4'b0000, 0, 1, 0, 64'h6000)); // flush beats push/pop
        vecs.push_back(v(0, 64'h0,    0, 0, 0, 4'b0000, 0, 1, 3, 64'h8000)); // payloads kept
        vecs.push_back(v(1, 64'hA000, 0, 0, 0, 4'b0001, 0, 0, 0, 64'hA000));
        vecs.push_back(v(0, 64'h0,    1, 2, 0, 4'b0001, 0, 0, 0, 64'hA000)); // pop of free slot
        vecs.push_back(v(0, 64'h0,    1, 0, 0, 4'b0000, 0, 1, 0, 64'hA000));

        // Reset state while RSTn is held low.
        idle_inputs();
        RSTn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_malloc", 128'(jal_buffer_malloc), 128'(4'b0000));
        chk("rst_empty",  128'(jal_buffer_empty),  128'(1'b1));
        chk("rst_full",   128'(jal_buffer_full),   128'(1'b0));
        chk("rst_info",   128'(jal_issue_info != '0), 128'(1'b0));
        @(negedge CLK);
        RSTn = 1'b1;

        // Table: drive on the falling edge, expectation enters the scoreboard, compare just after the rising edge.
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge CLK);
            cur = vecs[k];
            jal_dispat_push      = cur.push;
            jal_dispat_info      = mk(cur.pc);
            jal_buffer_pop       = cur.pop;
            jal_buffer_pop_index = cur.pidx;
            flush                = cur.fl;
            if (cur.push && jal_buffer_full && !cur.fl) dropped_seen++;
            sb.push_back(cur);
            @(posedge CLK);
            #1;
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_underflow: got 0 entries expected 1 at vector %0d", k);
            end else begin
                exp = sb.pop_front();
                chk($sformatf("v%0d_malloc", k), 128'(jal_buffer_malloc), 128'(exp.exp_malloc));
                chk($sformatf("v%0d_full", k),   128'(jal_buffer_full),   128'(exp.exp_full));
                chk($sformatf("v%0d_empty", k),  128'(jal_buffer_empty),  128'(exp.exp_empty));
                if (exp.slot >= 0) begin
                    slot_val = jal_issue_info[DW*exp.slot +: DW];
                    chk($sformatf("v%0d_slot%0d", k, exp.slot), 128'(slot_val), 128'(mk(exp.slot_pc)));
                end
            end
        end
        @(negedge CLK);
        idle_inputs();

        // Push-while-full protocol violations observed at the dispatch boundary.
        chk("dropped_push_count", 128'(dropped_seen), 128'(2));

        // Mid-run asynchronous reset: fill two slots, then drop RSTn between edges.
        jal_dispat_push = 1'b1; jal_dispat_info = mk(64'hB000);
        @(negedge CLK);
        jal_dispat_info = mk(64'hB004);
        @(negedge CLK);
        idle_inputs();
        #1;
        chk("pre_async_malloc", 128'(jal_buffer_malloc), 128'(4'b0011));
        @(posedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        chk("async_malloc", 128'(jal_buffer_malloc), 128'(4'b0000));
        chk("async_empty",  128'(jal_buffer_empty),  128'(1'b1));
        chk("async_full",   128'(jal_buffer_full),   128'(1'b0));
        chk("async_info",   128'(jal_issue_info != '0), 128'(1'b0));
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_idle", 128'(jal_buffer_malloc), 128'(4'b0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
